// File: rtl/disp_sched_if.sv
// rtl/disp_sched_if.sv - source/digit-field bundle between the display scheduler and its user
interface disp_sched_if;
    logic [3:0]  valid;
    logic [63:0] data_bus;
    logic        hold;
    logic        next;
    logic [1:0]  cur_src;
    logic        busy;
    logic        upd;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

    modport slave (
        input  valid, data_bus, hold, next,
        output cur_src, busy, upd, d1, d2, d3, d4, d5, d6, d7, d8
    );

    modport master (
        output valid, data_bus, hold, next,
        input  cur_src, busy, upd, d1, d2, d3, d4, d5, d6, d7, d8
    );
endinterface

// File: rtl/disp_sched.sv
// rtl/disp_sched.sv - round-robin source scheduler with serial binary-to-BCD for the 8-digit display
module disp_sched #(
    parameter int DWELL = 100000000,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    disp_sched_if.slave  sched
);
    typedef enum logic [1:0] {IDLE, CONV, DONE, SHOW} state_t;

    localparam int CW = $clog2(DWELL);
    localparam int BW = $clog2(W);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(W - 1);

    state_t        state_q, state_d;
    logic [1:0]    cur_src_q, cur_src_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [19:0]   bcd_q, bcd_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [5:0]    dig_q [0:7];
    logic [5:0]    dig_d [0:7];
    logic          upd_q, upd_d;

    logic [1:0]    sel, idx;
    logic          hit;
    logic [4:0]    nz;
    logic          en;

    function automatic logic [19:0] bcd_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int n = 0; n < 5; n++) begin
            if (b[4*n +: 4] >= 4'd5) r[4*n +: 4] = b[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Priority runs from cur_src+1 around to cur_src itself, which is checked last.
    always_comb begin
        hit = |sched.valid;
        sel = cur_src_q;
        idx = cur_src_q;
        for (int k = 4; k >= 1; k--) begin
            idx = cur_src_q + 2'(k);
            if (sched.valid[idx]) sel = idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        bit_d     = bit_q;
        dwell_d   = dwell_q;
        dig_d     = dig_q;
        upd_d     = 1'b0;
        en        = 1'b0;
        for (int k = 0; k < 5; k++) nz[k] = |bcd_q[4*k +: 4];

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    cur_src_d = sel;
                    sh_d      = sched.data_bus[int'(sel)*W +: W];
                    bcd_d     = '0;
                    bit_d     = '0;
                    state_d   = CONV;
                end else begin
                    for (int k = 0; k < 8; k++) dig_d[k] = '0;
                end
            end
            CONV: begin
                {bcd_d, sh_d} = {bcd_adj(bcd_q), sh_q} << 1;
                bit_d = bit_q + BW'(1);
                if (bit_q == BIT_LAST) state_d = DONE;
            end
            DONE: begin
                // A digit is lit if it or any more significant digit is nonzero; d1 always lit.
                for (int k = 0; k < 5; k++) begin
                    en       = (k == 0) || (|(nz >> k));
                    dig_d[k] = en ? {1'b1, bcd_q[4*k +: 4], 1'b0} : 6'd0;
                end
                dig_d[5] = '0;
                dig_d[6] = '0;
                dig_d[7] = {1'b1, 2'b00, cur_src_q, 1'b0};
                upd_d    = 1'b1;
                dwell_d  = '0;
                state_d  = SHOW;
            end
            SHOW: begin
                if (!sched.hold) dwell_d = dwell_q + CW'(1);
                if (sched.next || !sched.valid[cur_src_q] ||
                    (!sched.hold && dwell_q == DWELL_LAST))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_src_q <= 2'd3;
            sh_q      <= '0;
            bcd_q     <= '0;
            bit_q     <= '0;
            dwell_q   <= '0;
            upd_q     <= 1'b0;
            for (int k = 0; k < 8; k++) dig_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            cur_src_q <= cur_src_d;
            sh_q      <= sh_d;
            bcd_q     <= bcd_d;
            bit_q     <= bit_d;
            dwell_q   <= dwell_d;
            upd_q     <= upd_d;
            for (int k = 0; k < 8; k++) dig_q[k] <= dig_d[k];
        end
    end

    assign sched.cur_src = cur_src_q;
    assign sched.busy    = (state_q == CONV) || (state_q == DONE);
    assign sched.upd     = upd_q;
    assign sched.d1      = dig_q[0];
    assign sched.d2      = dig_q[1];
    assign sched.d3      = dig_q[2];
    assign sched.d4      = dig_q[3];
    assign sched.d5      = dig_q[4];
    assign sched.d6      = dig_q[5];
    assign sched.d7      = dig_q[6];
    assign sched.d8      = dig_q[7];
endmodule

// File: tb/tb_disp_sched.sv
// tb/tb_disp_sched.sv - self-checking bench for disp_sched
module tb_disp_sched;
    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    disp_sched_if dif();

    disp_sched #(.DWELL(DWELL), .W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (dif.slave)
    );

    typedef struct {
        logic [15:0] data;
        logic [5:0]  e1, e2, e3, e4, e5;
    } vec_t;

    typedef struct packed {
        logic [1:0]  src;
        logic [47:0] dig;
    } exp_t;

    vec_t tbl [8];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;
    int   n, bc, cnt;

    function automatic logic [47:0] digs(input logic [1:0] src,
                                         input logic [5:0] e1, e2, e3, e4, e5);
        return {1'b1, 2'b00, src, 1'b0, 6'h00, 6'h00, e5, e4, e3, e2, e1};
    endfunction

    function automatic logic [47:0] act_digs();
        return {dif.d8, dif.d7, dif.d6, dif.d5, dif.d4, dif.d3, dif.d2, dif.d1};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_vec(input logic [1:0] src, input vec_t v);
        exp_t e;
        e.src = src;
        e.dig = digs(src, v.e1, v.e2, v.e3, v.e4, v.e5);
        sb_q.push_back(e);
    endtask

    // Waits for upd (bounded), checks latency when exp_n > 0, then pops and compares the scoreboard.
    task automatic expect_upd(input string name, input int exp_n);
        exp_t e;
        n  = -1;
        bc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (dif.busy) bc++;
            if (dif.upd) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: upd timeout after 60 cycles", name);
        end else if (exp_n > 0) begin
            check({name, " latency"}, n, exp_n);
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " digits"}, act_digs(), e.dig);
            check({name, " cur_src"}, dif.cur_src, e.src);
        end
    endtask

    task automatic pulse_next();
        dif.next = 1'b1;
        @(negedge clk);
        dif.next = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'd12345, 6'h2A, 6'h28, 6'h26, 6'h24, 6'h22};
        tbl[1] = '{16'd7,     6'h2E, 6'h00, 6'h00, 6'h00, 6'h00};
        tbl[2] = '{16'd0,     6'h20, 6'h00, 6'h00, 6'h00, 6'h00};
        tbl[3] = '{16'd65535, 6'h2A, 6'h26, 6'h2A, 6'h2A, 6'h2C};
        tbl[4] = '{16'd1000,  6'h20, 6'h20, 6'h20, 6'h22, 6'h00};
        tbl[5] = '{16'd10009, 6'h32, 6'h20, 6'h20, 6'h20, 6'h22};
        tbl[6] = '{16'd90,    6'h20, 6'h32, 6'h00, 6'h00, 6'h00};
        tbl[7] = '{16'd4096,  6'h2C, 6'h32, 6'h20, 6'h28, 6'h00};

        dif.valid    = 4'b0001;
        dif.data_bus = '0;
        dif.data_bus[15:0] = tbl[0].data;
        dif.hold     = 1'b0;
        dif.next     = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);

        check("reset digits", act_digs(), 48'h0);
        check("reset cur_src", dif.cur_src, 2'd3);
        check("reset busy", dif.busy, 1'b0);
        check("reset upd", dif.upd, 1'b0);

        push_vec(2'd0, tbl[0]);
        rst = 1'b0;
        expect_upd("first 12345", 18);
        check("first busy cycles", bc, 17);

        for (int i = 1; i < 8; i++) begin
            dif.data_bus[15:0] = tbl[i].data;
            push_vec(2'd0, tbl[i]);
            pulse_next();
            expect_upd($sformatf("vec%0d", i), 18);
        end

        // Two-source rotation: data1=42, data3=65535.
        dif.data_bus[31:16] = 16'd42;
        dif.data_bus[63:48] = 16'd65535;
        for (int r = 0; r < 2; r++) begin
            push_vec(2'd1, '{16'd42, 6'h24, 6'h28, 6'h00, 6'h00, 6'h00});
            push_vec(2'd3, tbl[3]);
        end
        dif.valid = 4'b1010;
        expect_upd("rot0", 19);
        expect_upd("rot1", 26);
        expect_upd("rot2", 26);
        expect_upd("rot3", 26);

        dif.valid = 4'b0000;
        repeat (3) @(negedge clk);
        check("blank digits", act_digs(), 48'h0);
        check("blank cur_src", dif.cur_src, 2'd3);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (dif.upd || dif.busy) cnt++;
        end
        check("blank idle", cnt, 0);

        // Hold, forced rotation, and dropped source.
        dif.data_bus[15:0] = 16'd5;
        push_vec(2'd0, '{16'd5, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00});
        dif.valid = 4'b0001;
        expect_upd("hold start", 18);
        dif.hold = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (dif.upd || dif.busy) cnt++;
        end
        check("hold 100 cycles", cnt, 0);
        dif.data_bus[15:0] = 16'd77;
        push_vec(2'd0, '{16'd77, 6'h2E, 6'h2E, 6'h00, 6'h00, 6'h00});
        pulse_next();
        check("next idle busy", dif.busy, 1'b0);
        expect_upd("next during hold", 18);
        dif.data_bus[47:32] = 16'd300;
        push_vec(2'd2, '{16'd300, 6'h20, 6'h20, 6'h26, 6'h00, 6'h00});
        dif.valid = 4'b0100;
        expect_upd("drop valid", 19);
        dif.hold = 1'b0;

        // Reset in the middle of a conversion.
        dif.data_bus[15:0] = tbl[0].data;
        dif.valid = 4'b1111;
        pulse_next();
        repeat (5) @(negedge clk);
        check("mid conv busy", dif.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst digits", act_digs(), 48'h0);
        check("rst busy", dif.busy, 1'b0);
        check("rst upd", dif.upd, 1'b0);
        check("rst cur_src", dif.cur_src, 2'd3);
        push_vec(2'd0, tbl[0]);
        rst = 1'b0;
        expect_upd("restart", 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Time-shares the 8-digit Nexys A7 seven-segment display among up to four binary data sources.
- Selects sources round-robin with a programmable dwell time.
- Converts the selected 16-bit value to 5 BCD digits sequentially (shift-add-3, one bit per clock), so no combinational divide/modulo chain is needed.
- Drives the 6-bit digit fields {enable, value[3:0], dp} consumed by dspl_drv_NexysA7.

Parameters:
- DWELL, 100000000, clocks each source is shown before rotating (1 s at 100 MHz); minimum 2.
- W, 16, source data width; fixed at 16 in this block.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- valid  in  4  valid[i]=1: source i has data to show
- data_bus  in  64  source i value in data_bus[16*i+15:16*i], unsigned
- hold  in  1  freezes the dwell counter while high
- next  in  1  single-cycle pulse; forces an immediate rotation
- cur_src  out  2  index of the source currently selected
- busy  out  1  high during conversion (CONV and DONE)
- upd  out  1  one-cycle pulse when new digit fields are latched
- d1..d8  out  6 each  digit fields {en, val[3:0], dp}; d1 is least significant

Behaviour:
- Reset values: state=IDLE, cur_src=3 (so the first search starts at source 0), d1..d8=0, upd=0, busy=0, dwell count=0, shift/BCD registers=0.
- Reset mid-operation aborts everything; the reset values apply on the next cycle.
- IDLE state:
  - Searches valid starting at cur_src+1 mod 4 and wrapping, so cur_src itself is checked last.
  - On the first hit: registers cur_src, loads that source's data into the shift register, clears BCD to 0, bit count to 0, then goes to CONV.
  - If valid==0: stays in IDLE, cur_src holds, and d1..d8 are driven to 0 from the next cycle.
  - Otherwise the old digit fields stay until the update.
- CONV state, 16 cycles:
  - Each cycle, every BCD nibble >=5 gets +3.
  - Then {bcd[19:0], shreg[15:0]} shifts left by 1.
  - After the 16th shift, go to DONE.
  - Source data is captured once in IDLE; changes during CONV are ignored.
- DONE state, 1 cycle:
  - Latches d1..d5 from BCD nibbles 0..4.
  - d8={1, 2'b00, cur_src, 0}; d6=d7=0.
  - Pulses upd, clears the dwell count, goes to SHOW.
- Timing: if IDLE selects a source during cycle T, the digit fields are valid and upd=1 in cycle T+18. busy=1 during cycles T+1..T+17.
- Leading-zero blanking:
  - d1 always has en=1.
  - dk (k=2..5) has en=1 only if some digit j>=k is nonzero.
  - Blanked fields are all 0; all dp bits are 0.
- SHOW state:
  - Dwell counter increments each cycle unless hold=1.
  - At count==DWELL-1, go to IDLE.
  - next=1 goes to IDLE immediately, regardless of hold.
  - valid[cur_src] falling to 0 goes to IDLE immediately.
  - Simultaneous events all resolve to IDLE.
- A single valid source re-selects itself every DWELL, refreshing its value.
- Maximum value 65535 fits in 5 digits; no overflow case exists.

Test Plan:
- Reset, valid=0001, data0=12345:
  - d1..d5 = 0x2A, 0x28, 0x26, 0x24, 0x22; d8=0x20; d6=d7=0.
  - upd pulses exactly 18 cycles after rst falls (IDLE cycle T).
  - busy high for 17 cycles.
- data0=7, then data0=0 after the next rotation:
  - First: d1=0x2E, d2..d5=0.
  - Second: d1=0x20, d2..d5=0.
- data0=65535 -> d5..d1 = 0x2C, 0x2A, 0x2A, 0x26, 0x2A; data0=1000 -> d4=0x22, d3=d2=d1=0x20, d5=0.
- DWELL=8, valid=1010:
  - cur_src sequence is 1,3,1,3; each SHOW lasts 8 cycles.
  - Changing valid to 0000 blanks all fields and keeps cur_src.
- hold and forced rotation:
  - hold=1 in SHOW keeps the state for 100 cycles.
  - A next pulse during hold moves to IDLE the following cycle.
  - Dropping valid[cur_src] moves to IDLE the following cycle.
- rst pulse mid-CONV:
  - Next cycle: d1..d8=0, busy=0, upd=0.
  - Restart selects source 0 first when valid=1111.
